ibc_request_scheduler: RTL and testbench

//  Parametrised stimulus-side scheduler for the HEVC encoder IBC/reference cache bench.

---
 rtl/ibc_request_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_ibc_request_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ibc_request_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ibc_request_scheduler                                        |
// | Description : Holds each reference-cache request until the referenced      |
// |               region has been written back; drives the write-back scan.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ibc_request_scheduler #(
   parameter int BLOCK_SIZE   = 8,
   parameter int CTU_SIZE     = 64,
   parameter int IMG_WIDTH    = 1920,
   parameter int IMG_HEIGHT   = 1080,
   parameter int X_FILE_WIDTH = 32,
   parameter int SCAN_MODE    = 1,
   parameter int GUARD        = 0,
   parameter int IDX_W        = 12,
   parameter int POC_W        = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req_valid_in,
   input  logic [X_FILE_WIDTH-1:0]   req_x_in,
   input  logic [X_FILE_WIDTH-1:0]   req_y_in,
   output logic                      req_ready_out,
   input  logic                      cache_idle_in,
   output logic                      cache_valid_out,
   output logic [2*X_FILE_WIDTH-1:0] cache_req_data_out,
   output logic                      wb_en_out,
   input  logic                      wb_ack_in,
   output logic [IDX_W-1:0]          wb_x_idx_out,
   output logic [IDX_W-1:0]          wb_y_idx_out,
   output logic [POC_W-1:0]          wb_poc_out,
   output logic                      frame_end_out,
   output logic [15:0]               stall_cnt_out
);

   localparam logic [31:0]        c_X_BLKS = 32'((IMG_WIDTH + BLOCK_SIZE - 1) / BLOCK_SIZE);
   localparam logic [31:0]        c_Y_BLKS = 32'((IMG_HEIGHT + BLOCK_SIZE - 1) / BLOCK_SIZE);
   localparam logic [31:0]        c_CPB    = 32'(CTU_SIZE / BLOCK_SIZE);
   localparam logic [31:0]        c_T      = 32'(BLOCK_SIZE + GUARD);
   localparam int                 c_BS_SH  = $clog2(BLOCK_SIZE);
   localparam logic signed [63:0] c_XMAX   = 64'(IMG_WIDTH - 1);
   localparam logic signed [63:0] c_YMAX   = 64'(IMG_HEIGHT - 1);

   typedef enum logic [0:0] {
      S_CHECK = 1'b0,
      S_ISSUE = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [IDX_W-1:0]  r_x_idx, r_y_idx, r_ctu_x0, r_ctu_y0;
   logic [IDX_W-1:0]  w_nx, w_ny, w_ncx, w_ncy;
   logic [POC_W-1:0]  r_poc;
   logic              r_frame_end;
   logic [15:0]       r_stall_cnt;
   logic              w_wrap, w_wb_en, w_issue, w_safe;
   logic signed [63:0] w_sx, w_sy;
   logic [31:0]       w_rx, w_ry, w_px, w_py, w_rowtop;
   logic [31:0]       w_x32, w_y32, w_cx32, w_cy32;

   assign w_sx = {{(64-X_FILE_WIDTH){req_x_in[X_FILE_WIDTH-1]}}, req_x_in};
   assign w_sy = {{(64-X_FILE_WIDTH){req_y_in[X_FILE_WIDTH-1]}}, req_y_in};

   always_comb begin
      if (w_sx < 64'sd0)       w_rx = 32'd0;
      else if (w_sx > c_XMAX)  w_rx = c_XMAX[31:0];
      else                     w_rx = w_sx[31:0];
      if (w_sy < 64'sd0)       w_ry = 32'd0;
      else if (w_sy > c_YMAX)  w_ry = c_YMAX[31:0];
      else                     w_ry = w_sy[31:0];
   end

   assign w_x32    = 32'(r_x_idx);
   assign w_y32    = 32'(r_y_idx);
   assign w_cx32   = 32'(r_ctu_x0);
   assign w_cy32   = 32'(r_ctu_y0);
   assign w_px     = w_x32 << c_BS_SH;
   assign w_py     = w_y32 << c_BS_SH;
   assign w_rowtop = (SCAN_MODE == 1) ? (w_cy32 << c_BS_SH) : w_py;

   // The whole source rectangle (plus margin) must lie in already written rows or columns.
   assign w_safe = ((w_px > w_rx + c_T) && (w_py > w_ry + c_T)) || (w_rowtop > w_ry + c_T);

   // Next scan position; positions beyond the picture edge are skipped in the same step.
   always_comb begin
      w_nx   = r_x_idx;
      w_ny   = r_y_idx;
      w_ncx  = r_ctu_x0;
      w_ncy  = r_ctu_y0;
      w_wrap = 1'b0;
      if (SCAN_MODE == 0) begin
         if (w_x32 + 32'd1 < c_X_BLKS) begin
            w_nx = IDX_W'(w_x32 + 32'd1);
         end else if (w_y32 + 32'd1 < c_Y_BLKS) begin
            w_nx = '0;
            w_ny = IDX_W'(w_y32 + 32'd1);
         end else begin
            w_nx   = '0;
            w_ny   = '0;
            w_wrap = 1'b1;
         end
      end else begin
         if ((w_x32 - w_cx32 + 32'd1 < c_CPB) && (w_x32 + 32'd1 < c_X_BLKS)) begin
            w_nx = IDX_W'(w_x32 + 32'd1);
         end else if ((w_y32 - w_cy32 + 32'd1 < c_CPB) && (w_y32 + 32'd1 < c_Y_BLKS)) begin
            w_nx = r_ctu_x0;
            w_ny = IDX_W'(w_y32 + 32'd1);
         end else if (w_cx32 + c_CPB < c_X_BLKS) begin
            w_ncx = IDX_W'(w_cx32 + c_CPB);
            w_nx  = IDX_W'(w_cx32 + c_CPB);
            w_ny  = r_ctu_y0;
         end else if (w_cy32 + c_CPB < c_Y_BLKS) begin
            w_ncx = '0;
            w_ncy = IDX_W'(w_cy32 + c_CPB);
            w_nx  = '0;
            w_ny  = IDX_W'(w_cy32 + c_CPB);
         end else begin
            w_nx   = '0;
            w_ny   = '0;
            w_ncx  = '0;
            w_ncy  = '0;
            w_wrap = 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_wb_en     = 1'b0;
      w_issue     = 1'b0;
      if (!reset) begin
         case (r_state)
            S_CHECK: begin
               if (req_valid_in) begin
                  if (w_safe) w_state_nxt = S_ISSUE;
                  else        w_wb_en     = 1'b1;
               end
            end
            S_ISSUE: begin
               if (req_valid_in && cache_idle_in) begin
                  w_issue     = 1'b1;
                  w_state_nxt = S_CHECK;
               end
            end
            default: w_state_nxt = S_CHECK;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_CHECK;
         r_x_idx     <= '0;
         r_y_idx     <= '0;
         r_ctu_x0    <= '0;
         r_ctu_y0    <= '0;
         r_poc       <= '0;
         r_frame_end <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_frame_end <= 1'b0;
         if (w_wb_en) begin
            if (r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
            if (wb_ack_in) begin
               r_x_idx  <= w_nx;
               r_y_idx  <= w_ny;
               r_ctu_x0 <= w_ncx;
               r_ctu_y0 <= w_ncy;
               if (w_wrap) begin
                  r_poc       <= r_poc + 1'b1;
                  r_frame_end <= 1'b1;
               end
            end
         end
      end
   end

   assign req_ready_out      = w_issue;
   assign cache_valid_out    = w_issue;
   assign cache_req_data_out = w_issue ? {req_y_in, req_x_in} : '0;
   assign wb_en_out          = w_wb_en;
   assign wb_x_idx_out       = r_x_idx;
   assign wb_y_idx_out       = r_y_idx;
   assign wb_poc_out         = r_poc;
   assign frame_end_out      = r_frame_end;
   assign stall_cnt_out      = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ibc_request_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ibc_request_scheduler                                     |
// | Description : Directed bench for the CTU-scan and raster-scan schedulers.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ibc_request_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic        ctu_reset, ctu_req_valid, ctu_ready, ctu_idle, ctu_cvalid, ctu_wb_en, ctu_wb_ack, ctu_fend;
   logic [31:0] ctu_req_x, ctu_req_y;
   logic [63:0] ctu_data;
   logic [11:0] ctu_wb_x, ctu_wb_y;
   logic [15:0] ctu_poc, ctu_stall;

   logic        ras_reset, ras_req_valid, ras_ready, ras_idle, ras_cvalid, ras_wb_en, ras_wb_ack, ras_fend;
   logic [31:0] ras_req_x, ras_req_y;
   logic [63:0] ras_data;
   logic [11:0] ras_wb_x, ras_wb_y;
   logic [15:0] ras_poc, ras_stall;

   ibc_request_scheduler #(.SCAN_MODE(1)) dut_ctu (
      .clk(clk), .reset(ctu_reset), .req_valid_in(ctu_req_valid), .req_x_in(ctu_req_x),
      .req_y_in(ctu_req_y), .req_ready_out(ctu_ready), .cache_idle_in(ctu_idle),
      .cache_valid_out(ctu_cvalid), .cache_req_data_out(ctu_data), .wb_en_out(ctu_wb_en),
      .wb_ack_in(ctu_wb_ack), .wb_x_idx_out(ctu_wb_x), .wb_y_idx_out(ctu_wb_y),
      .wb_poc_out(ctu_poc), .frame_end_out(ctu_fend), .stall_cnt_out(ctu_stall)
   );

   ibc_request_scheduler #(.SCAN_MODE(0)) dut_ras (
      .clk(clk), .reset(ras_reset), .req_valid_in(ras_req_valid), .req_x_in(ras_req_x),
      .req_y_in(ras_req_y), .req_ready_out(ras_ready), .cache_idle_in(ras_idle),
      .cache_valid_out(ras_cvalid), .cache_req_data_out(ras_data), .wb_en_out(ras_wb_en),
      .wb_ack_in(ras_wb_ack), .wb_x_idx_out(ras_wb_x), .wb_y_idx_out(ras_wb_y),
      .wb_poc_out(ras_poc), .frame_end_out(ras_fend), .stall_cnt_out(ras_stall)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      ctu_reset = 1'b1; ctu_req_valid = 1'b0; ctu_req_x = '0; ctu_req_y = '0; ctu_idle = 1'b1; ctu_wb_ack = 1'b0;
      ras_reset = 1'b1; ras_req_valid = 1'b0; ras_req_x = '0; ras_req_y = '0; ras_idle = 1'b1; ras_wb_ack = 1'b0;
      fork
         begin : ctu_seq
            int  n;
            bit  seen, early;
            int  maxy;
            repeat (3) @(negedge clk);
            #1;
            check("ctu_rst_ptr", {ctu_wb_x, ctu_wb_y}, 0);
            check("ctu_rst_poc_stall", {ctu_poc, ctu_stall}, 0);
            check("ctu_rst_strobes", {ctu_cvalid, ctu_ready, ctu_wb_en, ctu_fend}, 0);
            check("ctu_rst_data", ctu_data, 0);

            // request (0,0): 18 write-backs, then issue
            ctu_reset = 1'b0; ctu_req_valid = 1'b1; ctu_wb_ack = 1'b1;
            n = 0; seen = 0;
            for (int c = 0; c < 200 && !seen; c++) begin
               #1;
               if (ctu_cvalid) seen = 1;
               else begin
                  if (ctu_wb_en) n++;
                  @(negedge clk);
               end
            end
            check("ctu00_seen", seen, 1);
            check("ctu00_acks", 64'(n), 18);
            check("ctu00_ptr", {ctu_wb_x, ctu_wb_y}, {12'd2, 12'd2});
            check("ctu00_data_ready", {ctu_data, ctu_ready}, {64'd0, 1'b1});
            @(negedge clk); #1;
            check("ctu00_one_cycle", ctu_cvalid, 0);
            ctu_req_valid = 1'b0;

            // full picture with a request that never becomes safe
            ctu_reset = 1'b1; @(negedge clk); @(negedge clk); #1;
            ctu_reset = 1'b0; ctu_req_x = 32'd5000; ctu_req_y = 32'd5000; ctu_req_valid = 1'b1;
            n = 0; early = 0; maxy = 0;
            for (int c = 0; c < 40000 && n < 32400; c++) begin
               #1;
               if (ctu_fend) early = 1;
               if (ctu_wb_en) begin
                  if (n == 64)    check("frm_ctu1", {ctu_wb_x, ctu_wb_y}, {12'd8, 12'd0});
                  if (n == 1920)  check("frm_row1", {ctu_wb_x, ctu_wb_y}, {12'd0, 12'd8});
                  if (n == 30720) check("frm_lastrow", {ctu_wb_x, ctu_wb_y}, {12'd0, 12'd128});
                  if (n == 30776) check("frm_partial_ctu", {ctu_wb_x, ctu_wb_y}, {12'd8, 12'd128});
                  if (n == 32399) check("frm_lastblk", {ctu_wb_x, ctu_wb_y}, {12'd239, 12'd134});
                  if (int'(ctu_wb_y) > maxy) maxy = int'(ctu_wb_y);
                  n++;
               end
               @(negedge clk);
            end
            #1;
            check("frm_acks", 64'(n), 32400);
            check("frm_maxy", 64'(maxy), 134);
            check("frm_no_early_end", early, 0);
            check("frm_end_pulse", ctu_fend, 1);
            check("frm_poc_ptr", {ctu_poc, ctu_wb_x, ctu_wb_y}, {16'd1, 12'd0, 12'd0});
            ctu_req_valid = 1'b0; ctu_wb_ack = 1'b0;
            @(negedge clk); #1;
            check("frm_end_single", ctu_fend, 0);

            // reset while in ISSUE
            ctu_req_x = '0; ctu_req_y = '0; ctu_req_valid = 1'b1; ctu_wb_ack = 1'b1; ctu_idle = 1'b0;
            n = 0; seen = 0;
            for (int c = 0; c < 200 && !seen; c++) begin
               #1;
               if (!ctu_wb_en) seen = 1;
               else begin
                  n++;
                  @(negedge clk);
               end
            end
            check("rsti_acks", 64'(n), 18);
            @(negedge clk); #1;
            check("rsti_hold", {ctu_cvalid, ctu_ready, ctu_wb_en}, 0);
            ctu_reset = 1'b1;
            @(negedge clk); #1;
            check("rsti_outputs", {ctu_cvalid, ctu_ready, ctu_wb_en, ctu_fend, ctu_data}, 0);
            check("rsti_state", {ctu_poc, ctu_wb_x, ctu_wb_y, ctu_stall}, 0);
            ctu_reset = 1'b0; ctu_idle = 1'b1;
            n = 0; seen = 0;
            for (int c = 0; c < 200 && !seen; c++) begin
               #1;
               if (ctu_cvalid) seen = 1;
               else begin
                  if (ctu_wb_en) n++;
                  @(negedge clk);
               end
            end
            check("rsti_reacks", 64'(n), 18);
            @(negedge clk); #1;
            ctu_req_valid = 1'b0;

            // negative request with cache busy for 10 cycles
            ctu_reset = 1'b1; @(negedge clk); @(negedge clk); #1;
            ctu_reset = 1'b0; ctu_req_x = 32'hFFFF_FFFB; ctu_req_y = 32'hFFFF_FFFD;
            ctu_req_valid = 1'b1; ctu_idle = 1'b0;
            n = 0; seen = 0;
            for (int c = 0; c < 200 && !seen; c++) begin
               #1;
               if (!ctu_wb_en) seen = 1;
               else begin
                  n++;
                  @(negedge clk);
               end
            end
            check("neg_acks", 64'(n), 18);
            for (int c = 0; c < 10; c++) begin
               @(negedge clk); #1;
               check("busy_strobes", {ctu_cvalid, ctu_ready, ctu_wb_en}, 0);
            end
            ctu_idle = 1'b1; #1;
            check("busy_release", {ctu_cvalid, ctu_ready, ctu_wb_en}, 3'b110);
            check("neg_data", ctu_data, 64'hFFFF_FFFD_FFFF_FFFB);
            @(negedge clk); #1;
            check("busy_one_cycle", {ctu_cvalid, ctu_ready}, 0);
            ctu_req_valid = 1'b0;
         end
         begin : ras_seq
            int n, gap;
            bit seen;
            repeat (3) @(negedge clk);
            #1;
            check("ras_rst_state", {ras_wb_x, ras_wb_y, ras_poc, ras_stall}, 0);
            check("ras_rst_strobes", {ras_cvalid, ras_ready, ras_wb_en, ras_fend}, 0);

            // raster request (0,0): two full block rows must be written
            ras_reset = 1'b0; ras_req_valid = 1'b1; ras_wb_ack = 1'b1;
            n = 0; gap = 0; seen = 0;
            for (int c = 0; c < 2000 && !seen; c++) begin
               #1;
               if (ras_cvalid) seen = 1;
               else begin
                  if (ras_wb_en) begin
                     n++;
                     gap = 0;
                  end else gap++;
                  @(negedge clk);
               end
            end
            check("ras_seen", seen, 1);
            check("ras_acks", 64'(n), 480);
            check("ras_latency", 64'(gap), 1);
            check("ras_ptr", {ras_wb_x, ras_wb_y}, {12'd0, 12'd2});
            check("ras_data_ready", {ras_data, ras_ready}, {64'd0, 1'b1});
            @(negedge clk); #1;
            check("ras_one_cycle", ras_cvalid, 0);
            ras_req_valid = 1'b0;
            check("ras_stall480", ras_stall, 480);

            // ack without a write-back request is ignored
            repeat (5) @(negedge clk);
            #1;
            check("ras_stray_ack", {ras_wb_x, ras_wb_y}, {12'd0, 12'd2});

            // unsafe request held with no acks
            ras_wb_ack = 1'b0; ras_req_x = 32'd1000; ras_req_y = 32'd1000; ras_req_valid = 1'b1;
            repeat (100) @(negedge clk);
            #1;
            check("ras_stall580", ras_stall, 580);
            check("ras_stall_wben", ras_wb_en, 1);
            repeat (65100) @(negedge clk);
            #1;
            check("ras_stall_sat", ras_stall, 16'hFFFF);
            check("ras_stall_ptr", {ras_wb_x, ras_wb_y, ras_poc}, {12'd0, 12'd2, 16'd0});
            ras_req_valid = 1'b0;
         end
      join
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
